// File: rtl/aoi_resp_checker.sv
// Response checker for an AOI gate: samples dut_o a programmable time after each
// applied vector, scores it against ~((a1&a2)|(b1&b2)) and tracks 16-vector coverage.
module aoi_resp_checker #(
  parameter int SETTLE = 2,
  parameter int ERR_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [3:0]       vec,
  input  logic             dut_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic [15:0]      cov_map,
  output logic [3:0]       first_err_vec,
  output logic             first_err_valid
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

  localparam logic [7:0]       SETTLE_CNT = 8'(SETTLE);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  state_t      state;
  logic [7:0]  cnt;
  logic [3:0]  cap_vec;
  logic        golden;
  logic        fail;
  logic [15:0] cov_upd;

  // Case inequality so an X/Z on dut_o is scored as a failure in simulation.
  always_comb begin
    golden  = ~((cap_vec[3] & cap_vec[2]) | (cap_vec[1] & cap_vec[0]));
    fail    = (dut_o !== golden);
    cov_upd = cov_map | (16'd1 << cap_vec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      cap_vec         <= '0;
      mismatch        <= 1'b0;
      err_cnt         <= '0;
      cov_map         <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (start) begin
        state           <= RUN;
        cnt             <= '0;
        cap_vec         <= '0;
        err_cnt         <= '0;
        cov_map         <= '0;
        first_err_vec   <= '0;
        first_err_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          RUN: begin
            if (vec_valid) begin
              cap_vec <= vec;
              cnt     <= SETTLE_CNT;
              state   <= WAIT;
            end
          end
          WAIT: begin
            if (cnt != 8'd0) begin
              // A new vector before the sample point abandons the pending compare.
              if (vec_valid) begin
                cap_vec <= vec;
                cnt     <= SETTLE_CNT;
              end else begin
                cnt <= cnt - 8'd1;
              end
            end else begin
              cov_map <= cov_upd;
              if (fail) begin
                mismatch <= 1'b1;
                if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
                if (!first_err_valid) begin
                  first_err_vec   <= cap_vec;
                  first_err_valid <= 1'b1;
                end
              end
              if (&cov_upd) begin
                state <= DONE;
              end else if (vec_valid) begin
                cap_vec <= vec;
                cnt     <= SETTLE_CNT;
              end else begin
                state <= RUN;
              end
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state == RUN) || (state == WAIT);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

endmodule

// File: doc/aoi_resp_checker.md
Name: aoi_resp_checker

Overview:
Response-side companion to the exhaustive AOI stimulus bench. It watches each applied 4-bit vector {a1,a2,b1,b2} and the AOI output under test, waits a programmable settle time, and compares the output against the golden function o = ~((a1&a2)|(b1&b2)). It tracks coverage of all 16 vectors, counts mismatches and latches the first failing vector. It reports pass/fail once coverage is complete, so the bench becomes self-checking instead of waveform-inspected.

Parameters:
SETTLE, 2, clock cycles waited after vec_valid before sampling dut_o (0..255)
ERR_W, 5, width of the saturating mismatch counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse: clear all results and enter RUN
vec_valid  input  1  one-cycle pulse: new vector applied this cycle
vec  input  4  applied vector {a1,a2,b1,b2}, MSB = a1
dut_o  input  1  AOI output under test
busy  output  1  high in RUN or WAIT
done  output  1  high in DONE (all 16 vectors covered)
pass  output  1  high in DONE when err_cnt == 0
mismatch  output  1  one-cycle pulse on a failing compare
err_cnt  output  ERR_W  mismatch count, saturates at 2^ERR_W-1
cov_map  output  16  bit i set once vector i has been compared
first_err_vec  output  4  vector of the first mismatch
first_err_valid  output  1  first_err_vec holds a valid value

Behaviour:
- Reset is asynchronous and active-high. While rst is high: state IDLE, all outputs 0, settle counter 0, captured vector 0.
- States:
  - IDLE: start -> RUN; vec_valid is ignored.
  - RUN: vec_valid -> capture vec, load counter with SETTLE, go to WAIT.
  - WAIT: if counter != 0, decrement.
  - WAIT compare: if counter == 0, compare dut_o against golden(captured vec). Set cov_map[vec]. Return to RUN, or go to DONE if cov_map becomes all ones.
  - DONE: hold results; only start leaves it (-> RUN).
- Latency: vec_valid sampled at edge k -> dut_o sampled at edge k+1+SETTLE. The mismatch pulse and the err_cnt / cov_map updates appear after that same edge. done rises on that edge when it is the 16th distinct vector.
- On a mismatch:
  - err_cnt increments, holding at the maximum value.
  - On the first mismatch only, first_err_vec is set to the captured vector and first_err_valid is set to 1.
- pass = done & (err_cnt == 0). It is combinational from registered state.
- vec_valid during WAIT: the pending compare is discarded (no coverage, no count). The new vector is captured and the counter reloads with SETTLE.
- vec_valid on the compare cycle (WAIT, counter == 0): the compare completes first. The new vector is then captured and the block stays in WAIT.
- Repeated vector: compared and counted again. cov_map is unchanged.
- start in any non-reset state: same cycle clears err_cnt, cov_map, first_err_*, mismatch, and any pending compare; next state RUN. If start and vec_valid are asserted together, start wins and the vector is dropped.
- dut_o equal to X/Z on a compare counts as a mismatch, using the !== golden comparison in simulation.
- Reset mid-operation aborts immediately; all results are lost.

Test Plan:
- Correct AOI model, SETTLE=2, vectors 0..15 one per 100 cycles -> cov_map=16'hFFFF, err_cnt=0, pass=1, done rises 3 clocks after the vec_valid for 4'b1111.
- Faulty model (output stuck at 1) -> mismatches on vectors 4'b0011, 4'b0111, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111. Expect err_cnt=7, first_err_vec=4'b0011, pass=0 at done.
- vec_valid for 4'b0011, then vec_valid for 4'b0101 one cycle later (during WAIT) -> cov_map bit 3 stays 0, bit 5 set, exactly one compare.
- ERR_W=2, inverted model over all 16 vectors -> err_cnt saturates at 3, mismatch pulses 16 times, first_err_vec=4'b0000.
- Vector 4'b0000 applied 3 times, then start pulse -> cov_map=16'h0001 before start; all counters 0 and busy=1 after start.
- rst asserted asynchronously mid-WAIT -> all outputs 0 without a clock edge. No compare occurs for the aborted vector after rst deasserts.
